// File: rtl/project_select_seq.sv
// project_select_seq: break-before-make sequencer for per-project enables.
// Optional heartbeat watchdog in RUN is built when PROJ_WDT_EN is defined.
module project_select_seq #(
    parameter int NUM_PROJ   = 8,
    parameter int GAP_CYCLES = 4,
    parameter int RST_CYCLES = 16,
    parameter int WDT_CYCLES = 65535
) (
    input  logic                wb_clk_i,
    input  logic                rst_n,
    input  logic                sel_req,
    input  logic [3:0]          sel_id,
    input  logic                heartbeat,
    output logic [NUM_PROJ-1:0] active,
    output logic                proj_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [3:0]          cur_id,
    output logic                wdt_trip
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RST,
        S_RUN
    } state_t;

    localparam int MAX_GR  = (GAP_CYCLES > RST_CYCLES) ?
                             GAP_CYCLES : RST_CYCLES;
    localparam int CNT_MAX = (MAX_GR > WDT_CYCLES) ?
                             MAX_GR : WDT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
`ifdef PROJ_WDT_EN
    localparam logic [CW-1:0] WDT_LD = CW'(WDT_CYCLES - 1);
`endif
    localparam logic [4:0]          NP5 = 5'(NUM_PROJ);
    localparam logic [NUM_PROJ-1:0] ONE = NUM_PROJ'(1);
    localparam logic [3:0]          NONE = 4'hF;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_tgt;
    logic [NUM_PROJ-1:0] r_active;
    logic                r_prst_n;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [3:0]          r_cur;
    // Set when sel_req was low last cycle; cleared by reset so a
    // level already high at reset release is not taken as an edge.
    logic                r_req_low;

    logic w_edge;
    logic w_valid;
    logic w_desel;

    assign w_edge  = sel_req & r_req_low;
    assign w_valid = ({1'b0, sel_id} < NP5);
    assign w_desel = (sel_id == NONE);

`ifdef PROJ_WDT_EN
    logic r_hb_q;
    logic r_wdt;
    logic w_hb_chg;

    assign w_hb_chg = heartbeat ^ r_hb_q;
    assign wdt_trip = r_wdt;
`else
    logic w_unused_hb;

    assign w_unused_hb = heartbeat;
    assign wdt_trip    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tgt     <= NONE;
            r_active  <= '0;
            r_prst_n  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cur     <= NONE;
            r_req_low <= 1'b0;
`ifdef PROJ_WDT_EN
            r_hb_q    <= 1'b0;
            r_wdt     <= 1'b0;
`endif
        end else begin
            r_req_low <= ~sel_req;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef PROJ_WDT_EN
            r_hb_q    <= heartbeat;
            r_wdt     <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        if (w_valid) begin
                            r_tgt   <= sel_id;
                            r_cnt   <= GAP_LD;
                            r_busy  <= 1'b1;
                            r_state <= S_DRAIN;
                        end else if (w_desel) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_edge) r_err <= 1'b1;
                    if (r_cnt == '0) begin
                        r_active <= ONE << r_tgt;
                        r_cur    <= r_tgt;
                        r_cnt    <= RST_LD;
                        r_state  <= S_RST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RST: begin
                    if (w_edge) r_err <= 1'b1;
                    if (r_cnt == '0) begin
                        r_prst_n <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
`ifdef PROJ_WDT_EN
                        r_cnt    <= WDT_LD;
`endif
                        r_state  <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_edge) begin
                        if (w_valid) begin
                            r_tgt    <= sel_id;
                            r_cnt    <= GAP_LD;
                            r_active <= '0;
                            r_prst_n <= 1'b0;
                            r_cur    <= NONE;
                            r_busy   <= 1'b1;
                            r_state  <= S_DRAIN;
                        end else if (w_desel) begin
                            r_active <= '0;
                            r_prst_n <= 1'b0;
                            r_cur    <= NONE;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
`ifdef PROJ_WDT_EN
                    // Expiry re-resets the same project; enable stays up.
                    else if (w_hb_chg) begin
                        r_cnt <= WDT_LD;
                    end else if (r_cnt == '0) begin
                        r_wdt    <= 1'b1;
                        r_prst_n <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= RST_LD;
                        r_state  <= S_RST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign active     = r_active;
    assign proj_rst_n = r_prst_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cur_id     = r_cur;

    a_onehot: assert property (
        @(posedge wb_clk_i) $countones(active) <= 1
    );

endmodule

// File: tb/tb_project_select_seq.sv
// tb_project_select_seq: directed checks of select, switch, errors, reset.
// Watchdog scenario is exercised when PROJ_WDT_EN is defined.
module tb_project_select_seq;

`ifdef PROJ_WDT_EN
    localparam int WDT = 100;
`else
    localparam int WDT = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel_req;
    logic [3:0] sel_id;
    logic       heartbeat;
    logic [7:0] active;
    logic       proj_rst_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] cur_id;
    logic       wdt_trip;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    project_select_seq #(
        .NUM_PROJ   (8),
        .GAP_CYCLES (4),
        .RST_CYCLES (16),
        .WDT_CYCLES (WDT)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .sel_req    (sel_req),
        .sel_id     (sel_id),
        .heartbeat  (heartbeat),
        .active     (active),
        .proj_rst_n (proj_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_id     (cur_id),
        .wdt_trip   (wdt_trip)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_cmd(input logic [3:0] id);
        sel_id  = id;
        sel_req = 1'b1;
        tick(1);
        sel_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel_req = 1'b0; sel_id = 4'h0; heartbeat = 1'b0;
        tick(3);
        n_checks += 7;
        if (active !== 8'h00) begin n_err++;
            $display("FAIL rst_active got %h exp 00", active); end
        if (proj_rst_n !== 1'b0) begin n_err++;
            $display("FAIL rst_prst got %b exp 0", proj_rst_n); end
        if (busy !== 1'b0) begin n_err++;
            $display("FAIL rst_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin n_err++;
            $display("FAIL rst_done got %b exp 0", done); end
        if (err !== 1'b0) begin n_err++;
            $display("FAIL rst_err got %b exp 0", err); end
        if (cur_id !== 4'hF) begin n_err++;
            $display("FAIL rst_cur got %h exp F", cur_id); end
        if (wdt_trip !== 1'b0) begin n_err++;
            $display("FAIL rst_wdt got %b exp 0", wdt_trip); end
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (active !== 8'h00 || busy !== 1'b0) begin n_err++;
            $display("FAIL rst_idle got act=%h busy=%b exp 00/0",
                     active, busy); end
    endtask

    task automatic test_select;
        logic [7:0] ea;
        logic [3:0] ec;
        pulse_cmd(4'd2);
        for (int c = 1; c <= 22; c++) begin
            ea = (c >= 5) ? 8'h04 : 8'h00;
            ec = (c >= 5) ? 4'd2 : 4'hF;
            n_checks += 5;
            if (active !== ea) begin n_err++;
                $display("FAIL sel_active c=%0d got %h exp %h", c, active, ea); end
            if (proj_rst_n !== (c >= 21)) begin n_err++;
                $display("FAIL sel_prst c=%0d got %b", c, proj_rst_n); end
            if (done !== (c == 21)) begin n_err++;
                $display("FAIL sel_done c=%0d got %b", c, done); end
            if (busy !== (c <= 20)) begin n_err++;
                $display("FAIL sel_busy c=%0d got %b", c, busy); end
            if (cur_id !== ec) begin n_err++;
                $display("FAIL sel_cur c=%0d got %h exp %h", c, cur_id, ec); end
            if (c < 22) tick(1);
        end
    endtask

    task automatic test_switch;
        logic [7:0] ea;
        logic [3:0] ec;
        pulse_cmd(4'd5);
        for (int c = 1; c <= 22; c++) begin
            ea = (c >= 5) ? 8'h20 : 8'h00;
            ec = (c >= 5) ? 4'd5 : 4'hF;
            n_checks += 5;
            if (active !== ea) begin n_err++;
                $display("FAIL sw_active c=%0d got %h exp %h", c, active, ea); end
            if ($countones(active) > 1) begin n_err++;
                $display("FAIL sw_onehot c=%0d got %h", c, active); end
            if (proj_rst_n !== (c >= 21)) begin n_err++;
                $display("FAIL sw_prst c=%0d got %b", c, proj_rst_n); end
            if (done !== (c == 21)) begin n_err++;
                $display("FAIL sw_done c=%0d got %b", c, done); end
            if (cur_id !== ec) begin n_err++;
                $display("FAIL sw_cur c=%0d got %h exp %h", c, cur_id, ec); end
            if (c < 22) tick(1);
        end
    endtask

    task automatic test_invalid;
        pulse_cmd(4'd9);
        n_checks += 4;
        if (err !== 1'b1) begin n_err++;
            $display("FAIL inv9_err got %b exp 1", err); end
        if (active !== 8'h20) begin n_err++;
            $display("FAIL inv9_active got %h exp 20", active); end
        if (cur_id !== 4'd5) begin n_err++;
            $display("FAIL inv9_cur got %h exp 5", cur_id); end
        if (proj_rst_n !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL inv9_state got prst=%b busy=%b exp 1/0",
                     proj_rst_n, busy); end
        tick(1);
        n_checks++;
        if (err !== 1'b0) begin n_err++;
            $display("FAIL inv9_errlen got %b exp 0", err); end
        pulse_cmd(4'd8);
        n_checks++;
        if (err !== 1'b1 || active !== 8'h20) begin n_err++;
            $display("FAIL inv8 got err=%b act=%h exp 1/20", err, active); end
        tick(1);
        pulse_cmd(4'hF);
        n_checks += 3;
        if (active !== 8'h00) begin n_err++;
            $display("FAIL desel_active got %h exp 00", active); end
        if (cur_id !== 4'hF) begin n_err++;
            $display("FAIL desel_cur got %h exp F", cur_id); end
        if (done !== 1'b1 || proj_rst_n !== 1'b0) begin n_err++;
            $display("FAIL desel_done got done=%b prst=%b exp 1/0",
                     done, proj_rst_n); end
        tick(1);
        n_checks++;
        if (done !== 1'b0) begin n_err++;
            $display("FAIL desel_donelen got %b exp 0", done); end
        pulse_cmd(4'hF);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || active !== 8'h00) begin n_err++;
            $display("FAIL idle_desel got done=%b busy=%b act=%h exp 1/0/00",
                     done, busy, active); end
        tick(1);
    endtask

    task automatic test_busy_drop;
        logic [7:0] ea;
        pulse_cmd(4'd3);
        tick(1);
        sel_id  = 4'd6;
        sel_req = 1'b1;
        tick(1);
        sel_req = 1'b0;
        for (int c = 3; c <= 22; c++) begin
            ea = (c >= 5) ? 8'h08 : 8'h00;
            n_checks += 4;
            if (err !== (c == 3)) begin n_err++;
                $display("FAIL bsy_err c=%0d got %b", c, err); end
            if (active !== ea) begin n_err++;
                $display("FAIL bsy_active c=%0d got %h exp %h", c, active, ea); end
            if (proj_rst_n !== (c >= 21)) begin n_err++;
                $display("FAIL bsy_prst c=%0d got %b", c, proj_rst_n); end
            if (done !== (c == 21)) begin n_err++;
                $display("FAIL bsy_done c=%0d got %b", c, done); end
            if (c < 22) tick(1);
        end
    endtask

    task automatic test_reset_mid;
        sel_id  = 4'd7;
        sel_req = 1'b1;
        tick(5);
        n_checks++;
        if (active !== 8'h80 || proj_rst_n !== 1'b0) begin n_err++;
            $display("FAIL mid_sel7 got act=%h prst=%b exp 80/0",
                     active, proj_rst_n); end
        tick(3);
        rst_n = 1'b0;
        tick(1);
        n_checks += 3;
        if (active !== 8'h00 || cur_id !== 4'hF) begin n_err++;
            $display("FAIL mid_rst got act=%h cur=%h exp 00/F",
                     active, cur_id); end
        if (busy !== 1'b0 || proj_rst_n !== 1'b0) begin n_err++;
            $display("FAIL mid_rst_bsy got busy=%b prst=%b exp 0/0",
                     busy, proj_rst_n); end
        if (done !== 1'b0 || err !== 1'b0) begin n_err++;
            $display("FAIL mid_rst_pulse got done=%b err=%b exp 0/0",
                     done, err); end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            n_checks++;
            if (busy !== 1'b0 || active !== 8'h00 || err !== 1'b0) begin
                n_err++;
                $display("FAIL mid_noedge c=%0d got busy=%b act=%h err=%b",
                         c, busy, active, err);
            end
        end
        sel_req = 1'b0;
        tick(1);
        pulse_cmd(4'd1);
        n_checks++;
        if (busy !== 1'b1) begin n_err++;
            $display("FAIL mid_rearm got busy=%b exp 1", busy); end
        tick(4);
        n_checks++;
        if (active !== 8'h02) begin n_err++;
            $display("FAIL mid_sel1 got %h exp 02", active); end
        tick(16);
        n_checks++;
        if (done !== 1'b1 || proj_rst_n !== 1'b1) begin n_err++;
            $display("FAIL mid_done got done=%b prst=%b exp 1/1",
                     done, proj_rst_n); end
    endtask

`ifdef PROJ_WDT_EN
    task automatic test_wdt;
        tick(99);
        n_checks++;
        if (wdt_trip !== 1'b0 || proj_rst_n !== 1'b1) begin n_err++;
            $display("FAIL wdt_early got trip=%b prst=%b exp 0/1",
                     wdt_trip, proj_rst_n); end
        tick(1);
        n_checks += 2;
        if (wdt_trip !== 1'b1) begin n_err++;
            $display("FAIL wdt_trip got %b exp 1", wdt_trip); end
        if (proj_rst_n !== 1'b0 || active !== 8'h02) begin n_err++;
            $display("FAIL wdt_rst got prst=%b act=%h exp 0/02",
                     proj_rst_n, active); end
        for (int c = 101; c <= 116; c++) begin
            tick(1);
            n_checks += 3;
            if (wdt_trip !== 1'b0) begin n_err++;
                $display("FAIL wdt_len c=%0d got %b exp 0", c, wdt_trip); end
            if (proj_rst_n !== (c == 116)) begin n_err++;
                $display("FAIL wdt_prst c=%0d got %b", c, proj_rst_n); end
            if (done !== (c == 116)) begin n_err++;
                $display("FAIL wdt_done c=%0d got %b", c, done); end
        end
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 50; c++) begin
                tick(1);
                n_checks++;
                if (wdt_trip !== 1'b0 || proj_rst_n !== 1'b1) begin
                    n_err++;
                    $display("FAIL wdt_hb k=%0d c=%0d got trip=%b prst=%b",
                             k, c, wdt_trip, proj_rst_n);
                end
            end
            heartbeat = ~heartbeat;
        end
    endtask
`else
    task automatic test_no_wdt;
        for (int c = 0; c < 200; c++) begin
            tick(1);
            n_checks++;
            if (wdt_trip !== 1'b0 || proj_rst_n !== 1'b1) begin
                n_err++;
                $display("FAIL nowdt c=%0d got trip=%b prst=%b exp 0/1",
                         c, wdt_trip, proj_rst_n);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_switch();
        test_invalid();
        test_busy_drop();
        test_reset_mid();
`ifdef PROJ_WDT_EN
        test_wdt();
`else
        test_no_wdt();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
